// File: rtl/eye_centroid.sv
// eye_centroid: binarised eye-region pixel stream -> 10.4 centroid of foreground pixels; result 16 cycles after end of frame.
// Optional CENTROID_MINPIX_EN: frames with fewer than MIN_PIX foreground pixels report cent_found=0 instead of a centroid.
module eye_centroid #(
  parameter int IMG_W   = 320,
  parameter int IMG_H   = 240,
  parameter int MIN_PIX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid,
  input  logic        pix_sof,
  input  logic        pix_bin,
  output logic [13:0] eye_x,
  output logic [13:0] eye_y,
  output logic        cent_valid,
  output logic        cent_found,
  output logic        busy
);
  localparam int CW = $clog2(IMG_W * IMG_H + 1);
  localparam int SW = CW + 10;
`ifdef CENTROID_MINPIX_EN
  localparam int THR = MIN_PIX;
`else
  localparam int THR = 1 + 0 * MIN_PIX;
`endif
  localparam logic [CW:0] THR_C    = (CW+1)'(THR);
  localparam logic [9:0]  LAST_COL = 10'(IMG_W - 1);
  localparam logic [9:0]  LAST_ROW = 10'(IMG_H - 1);
  // Position of the pixel that follows (0,0).
  localparam logic [9:0]  COL1     = (IMG_W == 1) ? 10'd0 : 10'd1;
  localparam logic [9:0]  ROW1     = (IMG_W == 1) ? 10'd1 : 10'd0;

  typedef enum logic {WAIT_SOF, ACCUM} acc_state_t;
  typedef enum logic {DIV_IDLE, DIV_RUN} div_state_t;

  acc_state_t    acc_state, acc_next;
  div_state_t    div_state, div_next;
  logic [9:0]    col, row;
  logic [SW-1:0] sum_x, sum_y;
  logic [CW-1:0] cnt;
  logic          sof, step, eof, eof_pend;

  assign sof  = pix_valid & pix_sof;
  assign step = pix_valid & ~pix_sof & (acc_state == ACCUM);
  assign eof  = step & (col == LAST_COL) & (row == LAST_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_state <= WAIT_SOF;
    else        acc_state <= acc_next;
  end

  always_comb begin
    acc_next = acc_state;
    if (sof)      acc_next = ACCUM;
    else if (eof) acc_next = WAIT_SOF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      row      <= '0;
      sum_x    <= '0;
      sum_y    <= '0;
      cnt      <= '0;
      eof_pend <= 1'b0;
    end else begin
      eof_pend <= eof;
      if (sof) begin
        col   <= COL1;
        row   <= ROW1;
        sum_x <= '0;
        sum_y <= '0;
        cnt   <= CW'(pix_bin);
      end else if (step) begin
        if (pix_bin) begin
          sum_x <= sum_x + SW'(col);
          sum_y <= sum_y + SW'(row);
          cnt   <= cnt + CW'(1);
        end
        if (col == LAST_COL) begin
          col <= '0;
          row <= row + 10'd1;
        end else begin
          col <= col + 10'd1;
        end
      end
    end
  end

  // Dividend is sum<<4. Its bits above the 14 quotient bits are always below cnt,
  // so they seed the partial remainder and only the low 14 bits need iterating.
  logic [CW-1:0] dcnt, rem_x, rem_y, nrem_x, nrem_y;
  logic [CW:0]   dcnt_w, trial_x, trial_y;
  logic [13:0]   quo_x, quo_y;
  logic          ge_x, ge_y, skip;
  logic [3:0]    iter;

  assign dcnt_w  = {1'b0, dcnt};
  assign trial_x = {rem_x, quo_x[13]};
  assign trial_y = {rem_y, quo_y[13]};
  assign ge_x    = (trial_x >= dcnt_w);
  assign ge_y    = (trial_y >= dcnt_w);
  assign nrem_x  = ge_x ? CW'(trial_x - dcnt_w) : trial_x[CW-1:0];
  assign nrem_y  = ge_y ? CW'(trial_y - dcnt_w) : trial_y[CW-1:0];
  assign busy    = (div_state == DIV_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_state <= DIV_IDLE;
    else        div_state <= div_next;
  end

  always_comb begin
    div_next = div_state;
    case (div_state)
      DIV_IDLE: if (eof_pend) div_next = DIV_RUN;
      DIV_RUN:  if (skip || iter == 4'd14) div_next = DIV_IDLE;
      default:  div_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt       <= '0;
      rem_x      <= '0;
      rem_y      <= '0;
      quo_x      <= '0;
      quo_y      <= '0;
      skip       <= 1'b0;
      iter       <= '0;
      eye_x      <= '0;
      eye_y      <= '0;
      cent_valid <= 1'b0;
      cent_found <= 1'b0;
    end else begin
      cent_valid <= 1'b0;
      if (eof_pend) begin
        rem_x <= sum_x[SW-1:10];
        rem_y <= sum_y[SW-1:10];
        quo_x <= {sum_x[9:0], 4'b0000};
        quo_y <= {sum_y[9:0], 4'b0000};
        dcnt  <= cnt;
        skip  <= ({1'b0, cnt} < THR_C);
        iter  <= '0;
      end else if (div_state == DIV_RUN) begin
        if (skip) begin
          cent_valid <= 1'b1;
          cent_found <= 1'b0;
        end else if (iter == 4'd14) begin
          eye_x      <= quo_x;
          eye_y      <= quo_y;
          cent_found <= 1'b1;
          cent_valid <= 1'b1;
        end else begin
          rem_x <= nrem_x;
          rem_y <= nrem_y;
          quo_x <= {quo_x[12:0], ge_x};
          quo_y <= {quo_y[12:0], ge_y};
          iter  <= iter + 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_eye_centroid.sv
// Bench for eye_centroid: a 205x88 instance for the large-coordinate cases and a 24x24 instance for
// table vectors, restart, reset-in-division and randomized frames checked against an arithmetic model.
module tb_eye_centroid;
  localparam int SM_W = 24, SM_H = 24;
  localparam int BG_W = 205, BG_H = 88;
`ifdef CENTROID_MINPIX_EN
  localparam int THR = 16;
`else
  localparam int THR = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        pix_valid = 1'b0, pix_sof = 1'b0, pix_bin = 1'b0;
  logic [13:0] eye_x, eye_y;
  logic        cent_valid, cent_found, busy;
  logic        b_valid = 1'b0, b_sof = 1'b0, b_bin = 1'b0;
  logic [13:0] b_x, b_y;
  logic        b_cv, b_found, b_busy;

  eye_centroid #(.IMG_W(SM_W), .IMG_H(SM_H), .MIN_PIX(16)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_bin(pix_bin),
    .eye_x(eye_x), .eye_y(eye_y), .cent_valid(cent_valid), .cent_found(cent_found), .busy(busy));

  eye_centroid #(.IMG_W(BG_W), .IMG_H(BG_H), .MIN_PIX(16)) dut_big (
    .clk(clk), .rst_n(rst_n), .pix_valid(b_valid), .pix_sof(b_sof), .pix_bin(b_bin),
    .eye_x(b_x), .eye_y(b_y), .cent_valid(b_cv), .cent_found(b_found), .busy(b_busy));

  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int x; int y; int f; longint c; } res_t;
  res_t resq[$];
  always @(negedge clk)
    if (cent_valid) resq.push_back('{int'(eye_x), int'(eye_y), int'(cent_found), cyc});

  bit fg [SM_H][SM_W];
  int last_x = 0, last_y = 0;

  typedef struct { int n; int cx[4]; int cy[4]; int fill_row; int ex; int ey; int ef; int el; } vec_t;
  vec_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_fg();
    foreach (fg[r, c]) fg[r][c] = 1'b0;
  endtask

  // Centroid from the foreground map; last_x/last_y carry the held output across skipped frames.
  task automatic model(output int ex, output int ey, output int ef, output int el);
    int n = 0, sx = 0, sy = 0;
    foreach (fg[r, c]) if (fg[r][c]) begin n++; sx += c; sy += r; end
    if (n >= THR) begin
      last_x = sx * 16 / n;
      last_y = sy * 16 / n;
      ef = 1; el = 16;
    end else begin
      ef = 0; el = 2;
    end
    ex = last_x; ey = last_y;
  endtask

  task automatic send_frame(input bit gaps, output longint eof);
    for (int r = 0; r < SM_H; r++)
      for (int c = 0; c < SM_W; c++) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          pix_valid = 1'b0;
          pix_sof   = 1'($urandom_range(0, 1));
          pix_bin   = 1'($urandom_range(0, 1));
          tick();
        end
        pix_valid = 1'b1;
        pix_sof   = (r == 0 && c == 0);
        pix_bin   = fg[r][c];
        tick();
      end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_bin   = 1'b0;
    eof = cyc;
  endtask

  task automatic expect_result(input string name, input int ex, input int ey, input int ef,
                               input int el, input longint eof);
    int   guard = 0;
    res_t r;
    while (resq.size() == 0 && guard < 60) begin tick(); guard++; end
    if (resq.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s_timeout: no cent_valid within 60 cycles, expected one", name);
    end else begin
      r = resq.pop_front();
      check({name, "_x"}, r.x, ex);
      check({name, "_y"}, r.y, ey);
      check({name, "_found"}, r.f, ef);
      check({name, "_latency"}, r.c - eof, el);
    end
  endtask

  task automatic big_frame(input string name, input int n, input int x0, input int y0,
                           input int x1, input int y1, input int ex, input int ey, input int ef);
    int k = 0;
    for (int r = 0; r < BG_H; r++)
      for (int c = 0; c < BG_W; c++) begin
        b_valid = 1'b1;
        b_sof   = (r == 0 && c == 0);
        b_bin   = (n > 0 && c == x0 && r == y0) || (n > 1 && c == x1 && r == y1);
        tick();
      end
    b_valid = 1'b0; b_sof = 1'b0; b_bin = 1'b0;
    while (!b_cv && k < 40) begin
      tick(); k++;
      if (k == 1 && ef == 1) check({name, "_busy_e1"}, b_busy, 1);
    end
    check({name, "_latency"}, k, (ef == 1) ? 16 : 2);
    check({name, "_x"}, b_x, ex);
    check({name, "_y"}, b_y, ey);
    check({name, "_found"}, b_found, ef);
    if (ef == 1) check({name, "_busy_done"}, b_busy, 0);
    tick();
    check({name, "_pulse_width"}, b_cv, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    longint eof, eof_a;
    int ex, ey, ef, el, ax, ay, af, al, dens;

`ifdef CENTROID_MINPIX_EN
    tbl[0] = '{1, '{10, 0, 0, 0}, '{5, 0, 0, 0}, -1,   0,  0, 0,  2};
    tbl[1] = '{0, '{0, 0, 0, 0},  '{0, 0, 0, 0}, -1,   0,  0, 0,  2};
    tbl[2] = '{3, '{0, 0, 1, 0},  '{0, 1, 2, 0}, -1,   0,  0, 0,  2};
    tbl[3] = '{4, '{23, 23, 0, 0}, '{7, 0, 7, 0}, -1,  0,  0, 0,  2};
    tbl[4] = '{0, '{0, 0, 0, 0},  '{0, 0, 0, 0},  3, 184, 48, 1, 16};
    tbl[5] = '{0, '{0, 0, 0, 0},  '{0, 0, 0, 0}, -1, 184, 48, 0,  2};
`else
    tbl[0] = '{1, '{10, 0, 0, 0}, '{5, 0, 0, 0}, -1, 160, 80, 1, 16};
    tbl[1] = '{0, '{0, 0, 0, 0},  '{0, 0, 0, 0}, -1, 160, 80, 0,  2};
    tbl[2] = '{3, '{0, 0, 1, 0},  '{0, 1, 2, 0}, -1,   5, 16, 1, 16};
    tbl[3] = '{4, '{23, 23, 0, 0}, '{7, 0, 7, 0}, -1, 184, 56, 1, 16};
    tbl[4] = '{0, '{0, 0, 0, 0},  '{0, 0, 0, 0},  3, 184, 48, 1, 16};
    tbl[5] = '{0, '{0, 0, 0, 0},  '{0, 0, 0, 0}, -1, 184, 48, 0,  2};
`endif

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_eye_x", eye_x, 0);
    check("rst_eye_y", eye_y, 0);
    check("rst_cent_valid", cent_valid, 0);
    check("rst_cent_found", cent_found, 0);
    check("rst_busy", busy, 0);

    // Large-coordinate frames on the wide instance.
    big_frame("big_one", 1, 203, 86, 0, 0, (1 >= THR) ? 3248 : 0, (1 >= THR) ? 1376 : 0, (1 >= THR) ? 1 : 0);
    big_frame("big_two", 2, 203, 86, 204, 87, (2 >= THR) ? 3256 : 0, (2 >= THR) ? 1384 : 0, (2 >= THR) ? 1 : 0);

    for (int i = 0; i < 6; i++) begin
      clear_fg();
      for (int j = 0; j < tbl[i].n; j++) fg[tbl[i].cy[j]][tbl[i].cx[j]] = 1'b1;
      if (tbl[i].fill_row >= 0)
        for (int c = 0; c < SM_W; c++) fg[tbl[i].fill_row][c] = 1'b1;
      model(ex, ey, ef, el);
      send_frame(1'b0, eof);
      expect_result($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ef, tbl[i].el, eof);
    end

    // Mid-frame sof after 50 foreground pixels discards the partial sums.
    for (int i = 0; i < 50; i++) begin
      pix_valid = 1'b1; pix_sof = (i == 0); pix_bin = 1'b1;
      tick();
    end
    clear_fg();
    fg[20][10] = 1'b1;
    model(ex, ey, ef, el);
    send_frame(1'b0, eof);
    expect_result("restart", ex, ey, ef, el, eof);

    // Reset at E+8 aborts the division without a pulse.
    clear_fg();
    for (int c = 0; c < SM_W; c++) fg[3][c] = 1'b1;
    send_frame(1'b0, eof);
    repeat (8) tick();
    rst_n = 1'b0;
    #1;
    check("rstdiv_eye_x", eye_x, 0);
    check("rstdiv_eye_y", eye_y, 0);
    check("rstdiv_found", cent_found, 0);
    check("rstdiv_busy", busy, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("rstdiv_no_pulse", resq.size(), 0);
    last_x = 0; last_y = 0;
    model(ex, ey, ef, el);
    send_frame(1'b0, eof);
    expect_result("after_rst", ex, ey, ef, el, eof);

    for (int f = 0; f < 6; f++) begin
      clear_fg();
      dens = (f == 2) ? 0 : $urandom_range(1, 40);
      foreach (fg[r, c]) fg[r][c] = ($urandom_range(0, 99) < dens);
      model(ex, ey, ef, el);
      send_frame(1'b1, eof);
      expect_result($sformatf("rand%0d", f), ex, ey, ef, el, eof);
    end

    // Back-to-back frames: the first result completes while the next frame streams in.
    clear_fg();
    foreach (fg[r, c]) fg[r][c] = ($urandom_range(0, 99) < 30);
    model(ax, ay, af, al);
    send_frame(1'b0, eof_a);
    clear_fg();
    foreach (fg[r, c]) fg[r][c] = ($urandom_range(0, 99) < 20);
    model(ex, ey, ef, el);
    send_frame(1'b1, eof);
    expect_result("b2b_a", ax, ay, af, al, eof_a);
    expect_result("b2b_b", ex, ey, ef, el, eof);

    repeat (20) tick();
    check("no_extra_results", resq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/eye_centroid.md
# eye_centroid

- Upstream stage of the iris-centre calculation.
- Reduces a binarised eye-region pixel stream to the centroid of all foreground pixels.
- Emits it as 10.4 fixed-point `eye_x`/`eye_y` (14 bits, 4 fractional bits), the exact format of the iris-centre block's `x`/`y` inputs.
- A frame accumulates coordinate sums and a pixel count. At end of frame a 14-iteration restoring divider produces the centroid.
- The divider runs concurrently with accumulation of the next frame.

## Interface
- `IMG_W`, 320, pixels per row (1..1023).
- `IMG_H`, 240, rows per frame (1..1023).
- `IMG_W*IMG_H` must be ≥ 16.
- `MIN_PIX`, 16, minimum foreground count for a valid centroid. Used only with `CENTROID_MINPIX_EN`.
- `clk` input 1: single clock, all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `pix_valid` input 1: pixel present this cycle.
- `pix_sof` input 1: qualified by `pix_valid`; marks pixel (0,0).
- `pix_bin` input 1: qualified by `pix_valid`; 1 = foreground.
- `eye_x` output 14: centroid column, 10.4 unsigned.
- `eye_y` output 14: centroid row, 10.4 unsigned.
- `cent_valid` output 1: one-cycle pulse; new result on `eye_x`/`eye_y`/`cent_found`.
- `cent_found` output 1: 1 = last result met the count threshold.
- `busy` output 1: divider running.

## Operation
- **Accumulator states:** WAIT_SOF and ACCUM. The divider is independent: DIV_IDLE, DIV_RUN.
- **After reset:** WAIT_SOF. Pixels are ignored until `pix_valid & pix_sof`.
- **Start of frame:** `pix_valid & pix_sof` sets col=0, row=0 and loads the accumulators with this pixel's contribution. This applies in any state, so a mid-frame sof restarts the frame and discards the partial sums.
- **Per valid pixel in ACCUM:**
  - If `pix_bin`: `sum_x += col`, `sum_y += row`, `cnt += 1`.
  - Col increments; at `IMG_W-1` it wraps to 0 and row increments.
  - Non-valid cycles hold all counters.
- **Accumulator widths:**
  - `cnt`: ceil(log2(IMG_W*IMG_H+1)) bits (17 at default).
  - `sum_x`/`sum_y`: 10 + `cnt` width (27 at default).
  - No overflow is possible.
- **End of frame:** the valid pixel at col=`IMG_W-1`, row=`IMG_H-1`. On the next edge:
  - `sum_x`, `sum_y`, `cnt` are copied into divider registers.
  - The accumulator returns to WAIT_SOF.
- **Threshold:**
  - Without the macro: if the copied cnt = 0, the divider skips computation. Next edge: `cent_valid`=1, `cent_found`=0, `eye_x`/`eye_y` hold.
  - Otherwise the divider computes `(sum<<4)/cnt` for x and y in parallel.
- **Division:**
  - Restoring, one quotient bit per cycle, 14 bits MSB first.
  - Truncating: remainder discarded, no rounding.
  - Quotient < `IMG_W`·16 always fits 14 bits.
- **Completion:** registers `eye_x`, `eye_y`, sets `cent_found`=1 and pulses `cent_valid`.
- **Output hold:** outputs hold between results.

## Timing
- **Reset values:** `eye_x`=0, `eye_y`=0, `cent_valid`=0, `cent_found`=0, `busy`=0. All counters 0, accumulator in WAIT_SOF.
- **Latency from end-of-frame:** edge E samples the end-of-frame pixel.
  - E+1: divider load, `busy`=1.
  - E+2..E+15: 14 iterations.
  - E+16: outputs update, `cent_valid`=1 for that one cycle, `busy`=0.
- **Zero-count (skip) path:** `cent_valid` at E+2.
- **Concurrency:** the next frame's pixels may arrive from E+1 on and are accumulated normally. The ≥16-pixel frame minimum guarantees the divider is idle at the next end-of-frame.
- **Reset mid-division:** the result is discarded, no `cent_valid` pulse, outputs go to their reset values.
- **No backpressure:** `pix_valid` is always accepted.

## Configuration
- **Macro:** `CENTROID_MINPIX_EN`.
- **Defined:** the threshold is `cnt < MIN_PIX`, which suppresses noise blobs. Below-threshold frames take the skip path: `cent_found`=0, outputs hold, `cent_valid` at E+2.
- **Undefined:** the threshold is `cnt = 0`; `MIN_PIX` is unused.

## Test plan
- **Single foreground pixel** at (203,86), default size, macro off → `eye_x`=3248, `eye_y`=1376, `cent_found`=1, `cent_valid` exactly 16 cycles after the end-of-frame edge.
- **Two pixels** (203,86) and (204,87) → `eye_x`=3256, `eye_y`=1384.
- **Truncation:** pixels at (0,0), (0,1), (1,2) → `eye_x`=5 (16/3 truncated), `eye_y`=16.
- **Empty frame** after a valid result → `cent_valid` at E+2, `cent_found`=0, `eye_x`/`eye_y` unchanged. With macro and `MIN_PIX`=16, a 3-pixel frame behaves the same.
- **Restart:** sof mid-frame after 50 foreground pixels, then a fresh frame with only (10,20) → `eye_x`=160, `eye_y`=320.
- **Reset during division:** `rst_n` low at E+8 → no `cent_valid`, all outputs 0. The next full frame produces the correct result.
